uart_tx: RTL and testbench
==========================

# uart_tx

UART transmit serializer sitting directly downstream of the TX-side `FIFO`. It pops one byte at a time through the FIFO's `rd`/`empty`/`r_data` interface and shifts it out on `tx` as an asynchronous serial frame: start bit, `DBIT` data bits LSB first, an optional parity bit, and stop bit(s). Bit timing comes from an external 16x oversampling tick, `s_tick`, produced by the sibling baud generator.

## Interface
- `DBIT`, 8: data bits per frame; must equal the FIFO data width.
- `SB_TICK`, 16: stop-bit duration in `s_tick` units; 16 gives 1 stop bit, 24 gives 1.5, 32 gives 2.
- `PAR_ODD`, 0: 0 selects even parity, 1 selects odd; only meaningful with `UART_TX_PARITY_EN`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `s_tick`  in  1  one-`clk` pulse at 16x the baud rate.
- `fifo_empty`  in  1  FIFO `empty`.
- `fifo_rdata`  in  DBIT  FIFO `r_data`, valid whenever `fifo_empty`=0.
- `fifo_rd`  out  1  FIFO `rd` pop strobe.
- `tx`  out  1  serial line, idle high, registered.
- `tx_busy`  out  1  high whenever the FSM is not in IDLE.
- `tx_done_tick`  out  1  one-`clk` pulse at the end of each frame's stop bit.

## Operation
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- Registers:
  - tick counter: 4 bits, counts 0..15, or up to `SB_TICK`-1 in STOP (width $clog2(`SB_TICK`)).
  - bit counter: $clog2(`DBIT`) bits.
  - shift register: `DBIT` bits.
  - `tx` register.
- IDLE:
  - `tx`=1.
  - When `fifo_empty`=0, `fifo_rd` is asserted combinationally in the same cycle.
  - On that edge, `fifo_rdata` is loaded into the shift register, both counters clear, and the FSM moves to START.
  - `fifo_rd` is never asserted outside IDLE and never while `fifo_empty`=1.
- START: `tx`=0. Counts `s_tick`. On the tick where the tick counter is 15, the counter clears and the FSM moves to DATA.
- DATA:
  - `tx`=shift[0].
  - On the tick where the tick counter is 15, the shift register shifts right and the bit counter increments.
  - After bit `DBIT`-1, the FSM moves to PARITY if enabled, otherwise to STOP.
- PARITY: `tx` = XOR of the captured byte, XOR `PAR_ODD`. Lasts 16 ticks, then STOP.
- STOP:
  - `tx`=1 for `SB_TICK` ticks.
  - On the final tick, `tx_done_tick` pulses and the FSM returns to IDLE.
- `s_tick` is ignored in IDLE. Ticks count only inside START, DATA, PARITY and STOP.
- Changes on `fifo_empty` or `fifo_rdata` mid-frame have no effect.

## Timing
- Reset values: `tx`=1, `fifo_rd`=0, `tx_busy`=0, `tx_done_tick`=0, state IDLE, all counters 0.
- `tx` is registered from next-state logic, so it changes on the same edge as the state.
- First start-bit cycle: the clock edge that samples `fifo_rd`=1.
- Frame length is 16·(1+`DBIT`+P)+`SB_TICK` ticks, where P=1 with parity and 0 without.
- Back-to-back frames:
  - After `tx_done_tick`, the FSM spends exactly one cycle in IDLE, with `tx`=1 and `fifo_rd` asserted if data is waiting.
  - The next start bit follows. The gap between stop bit and start bit is one `clk`.
- Reset asserted mid-frame:
  - `tx` goes to 1 immediately and asynchronously.
  - The in-flight byte is discarded, not re-read.
  - No `fifo_rd` is issued while `Reset`=0.
  - After release, transmission resumes from IDLE with the next FIFO entry.
- `s_tick` held high continuously is legal: each bit lasts 16 `clk`.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state and parity logic are compiled in, and each frame carries one parity bit selected by `PAR_ODD`.
- `UART_TX_PARITY_EN` undefined: no PARITY state and no parity logic; DATA goes directly to STOP, and `PAR_ODD` is ignored.

## Structure
- `uart_pkg`:
  - `tx_state_e` enum.
  - `OVERSAMPLE`=16.
  - `DEFAULT_DBIT`=8.
  - `DEFAULT_SB_TICK`=16.
- No sub-module. The counters, shift register and parity XOR stay inline. Baud tick generation stays in the separate baud generator block.

## Test plan
- **Reset:** hold `Reset`=0 with `fifo_empty`=0 -> `tx`=1, `fifo_rd`=0, `tx_busy`=0, `tx_done_tick`=0.
- **Single byte 0xA5:** `s_tick`=1 continuously -> one-cycle `fifo_rd`; `tx` low 16 clk; then bits 1,0,1,0,0,1,0,1 at 16 clk each; stop high 16 clk; `tx_done_tick` at clk 160.
- **Back-to-back 0x00 then 0xFF:**
  - Two `fifo_rd` pulses exactly 161 clk apart.
  - `tx` is high for 17 clk between the data bits of the two frames (16-clk stop bit plus one IDLE cycle).
- **Slow tick, 1.5 stop bits:** `s_tick` every 4 clk, `SB_TICK`=24 -> each bit 64 clk; stop bit 96 clk.
- **Reset mid-frame:** assert `Reset`=0 during DATA bit 3 of 0x3C -> `tx`=1 at once; byte is lost; after release, the next entry 0x81 is sent as a complete frame.
- **Parity:** with `UART_TX_PARITY_EN` defined, byte 0x07 with `PAR_ODD`=0 -> parity bit 1; with `PAR_ODD`=1 -> parity bit 0; frame length 176 clk at `s_tick`=1.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path.
// The state enum lists every state. PARITY is only reachable when
// uart_tx is built with UART_TX_PARITY_EN defined.
package uart_pkg;

  localparam int OVERSAMPLE      = 16;
  localparam int DEFAULT_DBIT    = 8;
  localparam int DEFAULT_SB_TICK = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // The tick counter covers one 16-tick bit and also the full stop period.
  // The stop period can be longer than 16 ticks (1.5 or 2 stop bits).
  function automatic int tick_width(input int sb_tick);
    int w;
    w = $clog2(sb_tick);
    return (w > 4) ? w : 4;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// uart_tx: UART transmit serializer fed from the TX FIFO.
// It pops one byte per frame through fifo_rd/fifo_empty/fifo_rdata.
// Each frame is a start bit, DBIT data bits LSB first, an optional
// parity bit and the stop period, timed by the 16x s_tick pulse.
// Optional feature macro: UART_TX_PARITY_EN. When it is defined, the
// PARITY state is compiled in and PAR_ODD selects odd parity.
//
// state  | meaning
// IDLE   | line high; pop the FIFO as soon as it holds data
// START  | start bit (tx=0), 16 ticks
// DATA   | data bits LSB first, 16 ticks each
// PARITY | parity bit, 16 ticks (UART_TX_PARITY_EN only)
// STOP   | line high for SB_TICK ticks; done pulse on the last tick
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT    = DEFAULT_DBIT,
  parameter int SB_TICK = DEFAULT_SB_TICK,
  parameter bit PAR_ODD = 1'b0
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic            s_tick,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_rdata,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int TW = tick_width(SB_TICK);
  localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_START  = ST_START;
  localparam logic [2:0] S_DATA   = ST_DATA;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = ST_PARITY;
`endif
  localparam logic [2:0] S_STOP   = ST_STOP;

  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DBIT - 1);

  logic [2:0]      r_state;
  logic [TW-1:0]   r_tick;
  logic [BW-1:0]   r_bit;
  logic [DBIT-1:0] r_shift;
  logic            r_tx;

  logic [2:0]      w_state_nxt;
  logic [TW-1:0]   w_tick_nxt;
  logic [BW-1:0]   w_bit_nxt;
  logic [DBIT-1:0] w_shift_nxt;
  logic            w_tx_nxt;
  logic            w_rd;
  logic            w_done;

`ifdef UART_TX_PARITY_EN
  logic r_par;
  logic w_par_nxt;
`else
  // PAR_ODD has no effect without parity support.
  logic w_unused_par_odd;
  assign w_unused_par_odd = PAR_ODD;
`endif

  // Next-state logic: frame sequencing, tick/bit counting, FIFO pop and done pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_rd        = 1'b0;
    w_done      = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        // The pop is gated by Reset so that no strobe leaks out while reset is held.
        if (!fifo_empty && Reset) begin
          w_rd        = 1'b1;
          w_shift_nxt = fifo_rdata;
          w_tick_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_START;
`ifdef UART_TX_PARITY_EN
          w_par_nxt   = (^fifo_rdata) ^ PAR_ODD;
`endif
        end
      end
      S_START: begin
        if (s_tick) begin
          if (r_tick == TICK_LAST) begin
            w_tick_nxt  = '0;
            w_state_nxt = S_DATA;
          end else begin
            w_tick_nxt = r_tick + TW'(1);
          end
        end
      end
      S_DATA: begin
        if (s_tick) begin
          if (r_tick == TICK_LAST) begin
            w_tick_nxt  = '0;
            w_shift_nxt = r_shift >> 1;
            if (r_bit == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              w_state_nxt = S_PARITY;
`else
              w_state_nxt = S_STOP;
`endif
            end else begin
              w_bit_nxt = r_bit + BW'(1);
            end
          end else begin
            w_tick_nxt = r_tick + TW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (s_tick) begin
          if (r_tick == TICK_LAST) begin
            w_tick_nxt  = '0;
            w_state_nxt = S_STOP;
          end else begin
            w_tick_nxt = r_tick + TW'(1);
          end
        end
      end
`endif
      S_STOP: begin
        if (s_tick) begin
          if (r_tick == STOP_LAST) begin
            w_tick_nxt  = '0;
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_tick_nxt = r_tick + TW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tick_nxt  = '0;
        w_bit_nxt   = '0;
      end
    endcase
  end

  // Line level for the coming cycle, so tx changes on the same edge as the state.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_nxt = w_par_nxt;
`endif
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  // State, counters, shift register and registered line output.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity of the captured byte, held for the whole frame because the shift register drains.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_par <= 1'b0;
    end else begin
      r_par <= w_par_nxt;
    end
  end
`endif

  assign tx           = r_tx;
  assign fifo_rd      = w_rd;
  assign tx_busy      = (r_state != S_IDLE);
  assign tx_done_tick = w_done;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx.
// Instance A (SB_TICK=16, s_tick held high) is fed from a queue-based
// FIFO model. Popped bytes go into an expected queue. A UART receiver
// model decodes the line mid-bit and checks each frame against that
// queue. Instance B (SB_TICK=24, s_tick every 4 clk) checks bit and
// stop-period durations.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int NB = 8;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam bit PODD_A  = 1'b0;
  localparam int FRAME_A = 16 * (1 + NB + P) + 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- instance A ----------------
  logic       Reset = 1'b0;
  logic       s_tick_a;
  logic       fifo_empty_a;
  logic [7:0] fifo_rdata_a;
  logic       fifo_rd_a, tx_a, tx_busy_a, tx_done_tick_a;

  uart_tx #(.DBIT(NB), .SB_TICK(16), .PAR_ODD(PODD_A)) u_dut (
    .clk(clk), .Reset(Reset), .s_tick(s_tick_a),
    .fifo_empty(fifo_empty_a), .fifo_rdata(fifo_rdata_a),
    .fifo_rd(fifo_rd_a), .tx(tx_a), .tx_busy(tx_busy_a), .tx_done_tick(tx_done_tick_a)
  );

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         rd_hist[$];
  int         rd_count    = 0;
  int         pushed      = 0;
  int         frames_rx   = 0;
  int         lost_frames = 0;
  bit         pop_pending = 0;
  bit         rx_active   = 0;
  int         rx_idx      = 0;
  logic [7:0] rx_byte;
  logic       rx_par;
  logic [7:0] exp_b;

  task automatic update_fifo();
    fifo_empty_a = (fifo_q.size() == 0);
    fifo_rdata_a = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    pushed++;
    update_fifo();
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while ((fifo_q.size() != 0 || rx_active || pop_pending || tx_busy_a) && n < budget) begin
      wait_cycles(1);
      n++;
    end
    n_checks++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL idle_timeout_%s: still busy after %0d cycles, required idle", tag, n);
    end
    wait_cycles(2);
  endtask

  // The FIFO pops just after the edge that sampled fifo_rd.
  initial forever begin
    @(posedge clk);
    #1;
    if (pop_pending) begin
      void'(fifo_q.pop_front());
      pop_pending = 0;
      update_fifo();
    end
  end

  // Receiver model and protocol monitor for A, sampled on the falling edge.
  always @(negedge clk) begin
    if (!Reset) begin
      check("rst_tx", tx_a, 1);
      check("rst_fifo_rd", fifo_rd_a, 0);
      check("rst_busy", tx_busy_a, 0);
      if (rx_active) begin
        rx_active = 0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        lost_frames++;
      end
    end else begin
      if (!rx_active && tx_a === 1'b0) begin
        rx_active = 1;
        rx_idx    = 0;
      end
      check("tx_busy", tx_busy_a, rx_active);
      check("fifo_rd", fifo_rd_a, (!rx_active && !fifo_empty_a));
      if (fifo_rd_a === 1'b1 && !fifo_empty_a) begin
        exp_q.push_back(fifo_q[0]);
        rd_hist.push_back(cyc);
        rd_count++;
        pop_pending = 1;
      end
      if (rx_active) begin
        if (rx_idx == 8) check("start_bit", tx_a, 0);
        for (int i = 0; i < NB; i++)
          if (rx_idx == 16 * (i + 1) + 8) rx_byte[i] = tx_a;
`ifdef UART_TX_PARITY_EN
        if (rx_idx == 16 * (1 + NB) + 8) rx_par = tx_a;
`endif
        if (rx_idx == 16 * (1 + NB + P) + 8) check("stop_bit", tx_a, 1);
        check("done_tick", tx_done_tick_a, (rx_idx == FRAME_A - 1));
        if (rx_idx == FRAME_A - 1) begin
          frames_rx++;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL frame_expected at cycle %0d: got frame %0h, expected none", cyc, rx_byte);
          end else begin
            exp_b = exp_q.pop_front();
            check("data_byte", rx_byte, exp_b);
`ifdef UART_TX_PARITY_EN
            check("parity_bit", rx_par, (^exp_b) ^ PODD_A);
`endif
            check("frame_len", cyc - rd_hist[$], FRAME_A);
          end
          rx_active = 0;
        end
        rx_idx++;
      end else begin
        check("idle_done", tx_done_tick_a, 0);
      end
    end
  end

  // ---------------- instance B ----------------
  logic       rst_n_b = 1'b0;
  logic       s_tick_b = 1'b0;
  logic       fifo_empty_b = 1'b1;
  logic [7:0] fifo_rdata_b = 8'h15;
  logic       fifo_rd_b, tx_b, tx_busy_b, tx_done_tick_b;
  bit         b_done = 0;

  uart_tx #(.DBIT(NB), .SB_TICK(24), .PAR_ODD(1'b1)) u_dut_b (
    .clk(clk), .Reset(rst_n_b), .s_tick(s_tick_b),
    .fifo_empty(fifo_empty_b), .fifo_rdata(fifo_rdata_b),
    .fifo_rd(fifo_rd_b), .tx(tx_b), .tx_busy(tx_busy_b), .tx_done_tick(tx_done_tick_b)
  );

  initial begin
    int tcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      tcnt++;
      s_tick_b = ((tcnt % 4) == 0);
    end
  end

  // 0x15 LSB first is 1,0,1,0,1,0,0,0. Parity (odd) is 0, so the line
  // has 8 transitions and the last rise opens the stop period.
  initial begin
    int  changes[$];
    int  done_c = -1;
    int  n = 0;
    logic prev = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n_b = 1'b1;
    wait_cycles(3);
    fifo_empty_b = 1'b0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (fifo_rd_b) break;
    end
    @(posedge clk);
    #2 fifo_empty_b = 1'b1;
    n = 0;
    while (n < 3000 && done_c < 0) begin
      @(negedge clk);
      n++;
      if (tx_b !== prev) changes.push_back(cyc);
      prev = tx_b;
      if (tx_done_tick_b) done_c = cyc;
    end
    check("b_transitions", changes.size(), 8);
    n_checks++;
    if (done_c < 0) begin
      n_fail++;
      $display("FAIL b_done_timeout: no done tick within %0d cycles, required one", n);
    end else if (changes.size() == 8) begin
      check("b_d0_len", changes[2] - changes[1], 64);
      check("b_d1_len", changes[3] - changes[2], 64);
      check("b_stop_len", done_c - changes[7] + 1, 96);
    end
    b_done = 1;
  end

  // ---------------- main stimulus for A ----------------
  initial begin
    int rc;
    int n;
    s_tick_a = 1'b1;
    Reset    = 1'b0;
    update_fifo();

    // Reset held with data waiting.
    push_byte(8'hA5);
    wait_cycles(5);
    check("reset_tx", tx_a, 1);
    check("reset_fifo_rd", fifo_rd_a, 0);
    check("reset_busy", tx_busy_a, 0);
    check("reset_done", tx_done_tick_a, 0);
    Reset = 1'b1;
    wait_idle(2000, "a5");

    // Back-to-back frames.
    rc = rd_hist.size();
    push_byte(8'h00);
    push_byte(8'hFF);
    wait_idle(2000, "b2b");
    check("b2b_rd_count", rd_hist.size() - rc, 2);
    if (rd_hist.size() - rc == 2)
      check("b2b_rd_spacing", rd_hist[rc + 1] - rd_hist[rc], FRAME_A + 1);

    push_byte(8'h07);
    wait_idle(2000, "par07");

    // Reset during data bit 3 of 0x3C; 0x81 must follow as a full frame.
    rc = rd_count;
    push_byte(8'h3C);
    push_byte(8'h81);
    n = 0;
    while (rd_count == rc && n < 100) begin
      wait_cycles(1);
      n++;
    end
    check("rst_mid_rd_seen", rd_count - rc, 1);
    wait_cycles(70);
    check("pre_rst_busy", tx_busy_a, 1);
    Reset = 1'b0;
    #1;
    check("async_rst_tx", tx_a, 1);
    check("async_rst_busy", tx_busy_a, 0);
    check("async_rst_rd", fifo_rd_a, 0);
    wait_cycles(5);
    Reset = 1'b1;
    wait_idle(2000, "rst_mid");
    check("lost_frames", lost_frames, 1);
    check("fifo_rd_after_rst", rd_count - rc, 2);

    // Random bytes with random spacing.
    for (int k = 0; k < 12; k++) begin
      push_byte(8'($urandom_range(0, 255)));
      wait_cycles($urandom_range(0, 200));
    end
    wait_idle(20000, "random");
    check("frames_received", frames_rx, pushed - lost_frames);
    check("exp_queue_empty", exp_q.size(), 0);

    n = 0;
    while (!b_done && n < 5000) begin
      wait_cycles(1);
      n++;
    end
    n_checks++;
    if (!b_done) begin
      n_fail++;
      $display("FAIL b_finish_timeout: instance B not finished after %0d cycles", n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
